reg_pair_fetch: RTL
===================

REG_PAIR_FETCH -- requirements
Module: reg_pair_fetch

Interface
REQ-001 Parameter DATA_W, default 4, SHALL set the register entry and read-data width.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of register entries; address width is ADDR_W = clog2(DEPTH) = 3.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port we, input, 1: write enable for the register array.
REQ-006 Port waddr, input, ADDR_W: write address.
REQ-007 Port wdata, input, DATA_W: write data.
REQ-008 Port req, input, 1: request a pair read.
REQ-009 Port addr_a, input, ADDR_W: first operand address, sampled with req.
REQ-010 Port addr_b, input, ADDR_W: second operand address, sampled with req.
REQ-011 Port busy, output, 1: high while a request is in progress.
REQ-012 Port ReadDataA2, output, DATA_W: operand A to the downstream comparator.
REQ-013 Port ReadDataB, output, DATA_W: operand B to the downstream comparator.
REQ-014 Port start, output, 1: one-cycle qualifier for ReadDataA2/ReadDataB.

Function
REQ-015 Storage SHALL be a DEPTH x DATA_W register array with one write port and two read ports.
REQ-016 A write SHALL occur at the clk edge when we=1, in any FSM state.
REQ-017 The FSM SHALL have exactly three states: IDLE, READ, VALID.
REQ-018 IDLE with req=1 SHALL latch addr_a/addr_b and move to READ; IDLE with req=0 SHALL stay in IDLE.
REQ-019 READ SHALL register array[addr_a] into ReadDataA2 and array[addr_b] into ReadDataB, then move to VALID.
REQ-020 VALID SHALL assert start=1 for exactly one cycle, then return to IDLE.
REQ-021 Latency SHALL be fixed: req seen at edge N gives start=1 during cycle N+2.
REQ-022 busy SHALL be 1 in READ and VALID and 0 in IDLE.
REQ-023 req while busy=1 SHALL be ignored; it is neither queued nor does it alter the latched addresses.
REQ-024 ReadDataA2/ReadDataB SHALL hold their values after start falls until the next READ state.
REQ-025 Write/read collision: if we=1 and waddr matches a latched address in the READ cycle, the captured operand SHALL be wdata (write-first forwarding).
REQ-026 addr_a = addr_b SHALL be legal; both outputs then carry the same entry.
REQ-027 A new req SHALL be accepted in the cycle after VALID, so back-to-back requests complete every 3 cycles.
REQ-028 Addresses are always in range for DEPTH = 2^ADDR_W; no wrap-around handling is required.

Reset
REQ-029 rst=1 SHALL clear every array entry to 0, set state to IDLE, and drive busy=0, start=0, ReadDataA2=0 and ReadDataB=0 at the next edge.
REQ-030 rst SHALL take priority over we and req in the same cycle.
REQ-031 rst during READ or VALID SHALL abort the request; no start pulse follows.

Structure
REQ-032 Package reg_pair_pkg SHALL hold the DATA_W/DEPTH/ADDR_W defaults and the state type (IDLE, READ, VALID).
REQ-033 The array SHALL be the sub-module regfile_2r1w (one write port, two read ports, forwarding).
REQ-034 The FSM and output registers SHALL be in reg_pair_fetch.

Verification
REQ-035 Reset: after rst, read of (0,7) -> ReadDataA2=0, ReadDataB=0, start pulse at N+2.
REQ-036 Basic read: write 3->9 and 5->4, req(3,5) -> start for 1 cycle with ReadDataA2=9, ReadDataB=4, busy high for 2 cycles.
REQ-037 Collision: req(2,6), then we waddr=6 wdata=12 during the READ cycle -> ReadDataB=12.
REQ-038 Busy drop: req(1,2), then req(4,4) one cycle later -> single start pulse carrying entries 1 and 2 only.
REQ-039 Abort: req, then rst in the VALID cycle -> no start pulse; all outputs 0.
REQ-040 Back-to-back: req at cycles 0 and 3 -> start pulses at cycles 2 and 5, each with correct data; outputs held between pulses.

Source files
------------

// File: rtl/reg_pair_pkg.sv
// Shared sizing defaults and FSM state encoding for the register-pair fetch unit.
package reg_pair_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t VALID = 2'd2;

endpackage

// File: rtl/reg_pair_fetch_regfile.sv
// DEPTH x DATA_W register array: one write port and two asynchronous read ports.
// A read that hits the address being written returns the incoming write data.
module regfile_2r1w
    import reg_pair_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    // Flops rather than block RAM: every entry must clear on reset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mem_q[raddr_a];
    assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mem_q[raddr_b];

endmodule

// File: rtl/reg_pair_fetch.sv
// Fetches two register operands per request through IDLE -> READ -> VALID and
// presents them with a one-cycle start qualifier to a downstream comparator.
module reg_pair_fetch
    import reg_pair_pkg::*;
#(
    parameter int  DATA_W = DATA_W_DEF,
    parameter int  DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              busy,
    output logic [DATA_W-1:0] ReadDataA2,
    output logic [DATA_W-1:0] ReadDataB,
    output logic              start
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_a_q, addr_b_q;
    logic [DATA_W-1:0] rd_a_q, rd_b_q;
    logic [DATA_W-1:0] rf_a, rf_b;

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .srst    (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (addr_a_q),
        .raddr_b (addr_b_q),
        .rdata_a (rf_a),
        .rdata_b (rf_b)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = READ;
            READ:    state_d = VALID;
            VALID:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Addresses latch only from IDLE, so a req while busy leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            rd_a_q   <= '0;
            rd_b_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                addr_a_q <= addr_a;
                addr_b_q <= addr_b;
            end
            if (state_q == READ) begin
                rd_a_q <= rf_a;
                rd_b_q <= rf_b;
            end
        end
    end

    assign busy       = (state_q != IDLE);
    // A reset arriving during VALID suppresses the pulse in that same cycle.
    assign start      = (state_q == VALID) && !rst;
    assign ReadDataA2 = rd_a_q;
    assign ReadDataB  = rd_b_q;

endmodule
